shift_unit: RTL and testbench

Parametrised, multi-cycle iterative shifter replacing the fixed-distance shift blocks in the ALU. Handles logical left, logical right, arithmetic right and rotate right by any amount from 0 to WIDTH-1. The shift is decomposed into log2(WIDTH) power-of-two stages, processed STAGES_PER_CYCLE at a time. It sits beside the ALU behind a valid/ready handshake, so the processor stalls on it like any other multi-cycle unit.

---
 rtl/shift_unit.sv | 97 +++++++++
 tb/tb_shift_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Multi-cycle iterative shifter: SLL/SRL/SRA/ROR decomposed into power-of-two
// stages, STAGES_PER_CYCLE of them applied per busy cycle, behind valid/ready.
module shift_unit #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned STAGES_PER_CYCLE = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned NCYC    = (SHAMT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  localparam int unsigned CNT_W   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_t;

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   nxt;
  logic [SHAMT_W-1:0] shamt_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt;
  int unsigned        k;
  int unsigned        d;

  assign in_ready = (state == IDLE) & reset_n;

  // Stage indices past SHAMT_W-1 (last cycle when S does not divide SHAMT_W)
  // select no shamt bit, so they pass data through.
  always_comb begin
    nxt = work;
    k   = '0;
    d   = '0;
    for (int unsigned j = 0; j < STAGES_PER_CYCLE; j++) begin
      k = 32'(cnt) * STAGES_PER_CYCLE + j;
      if (|(shamt_q & (SHAMT_W'(1) << k))) begin
        d = 32'd1 << k;
        case (op_q)
          OP_SLL: nxt = nxt << d;
          OP_SRL: nxt = nxt >> d;
          OP_SRA: nxt = (nxt >> d) | (sign_q ? ~(ONES >> d) : '0);
          OP_ROR: nxt = (nxt >> d) | (nxt << (WIDTH - d));
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      work      <= '0;
      shamt_q   <= '0;
      op_q      <= OP_SLL;
      sign_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work    <= in_data;
          shamt_q <= in_shamt;
          op_q    <= op_t'(in_op);
          sign_q  <= in_data[WIDTH-1];
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          work <= nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(NCYC - 1)) begin
            out_data  <= nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: default config directed tests, S=2 random
// regression, and WIDTH=8/S=3 exhaustive sweep, checked with immediate asserts.
module tb_shift_unit;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        iv0, ir0, ov0, or0;
  logic [31:0] d0, q0;
  logic [4:0]  s0;
  logic [1:0]  op0;
  logic        iv1, ir1, ov1, or1;
  logic [31:0] d1, q1;
  logic [4:0]  s1;
  logic [1:0]  op1;
  logic        iv2, ir2, ov2, or2;
  logic [7:0]  d2, q2;
  logic [2:0]  s2;
  logic [1:0]  op2;

  shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(1)) u0 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .in_shamt(s0), .in_op(op0), .out_valid(ov0), .out_ready(or0), .out_data(q0));
  shift_unit #(.WIDTH(32), .STAGES_PER_CYCLE(2)) u1 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .in_shamt(s1), .in_op(op1), .out_valid(ov1), .out_ready(or1), .out_data(q1));
  shift_unit #(.WIDTH(8), .STAGES_PER_CYCLE(3)) u2 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2), .in_data(d2),
    .in_shamt(s2), .in_op(op2), .out_valid(ov2), .out_ready(or2), .out_data(q2));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bitwise reference: each result bit is picked from its source position.
  function automatic logic [31:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] d, input int s);
    logic [31:0] r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00: r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b01: r[i] = (i + s < w) ? d[i+s] : 1'b0;
        2'b10: r[i] = (i + s < w) ? d[i+s] : d[w-1];
        default: r[i] = d[(i+s) % w];
      endcase
    end
    return r;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [1:0] op,
                        input logic [31:0] d, input logic [4:0] s);
    case (k)
      0: begin iv0 = v; op0 = op; d0 = d; s0 = s; end
      1: begin iv1 = v; op1 = op; d1 = d; s1 = s; end
      default: begin iv2 = v; op2 = op; d2 = d[7:0]; s2 = s[2:0]; end
    endcase
  endtask

  task automatic get_out(input int k, output logic v, output logic r, output logic [31:0] q);
    case (k)
      0: begin v = ov0; r = ir0; q = q0; end
      1: begin v = ov1; r = ir1; q = q1; end
      default: begin v = ov2; r = ir2; q = {24'd0, q2}; end
    endcase
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One transaction; with complete=1 the result handshake is also checked.
  task automatic run_op(input int k, input int w, input int ncyc, input logic [1:0] op,
                        input logic [31:0] d, input int s, input bit complete, input string tag);
    logic v, r;
    logic [31:0] q, e;
    int n;
    get_out(k, v, r, q);
    check({tag, " in_ready"}, 32'(r), 32'd1);
    set_in(k, 1'b1, op, d, 5'(s));
    exp_q.push_back(model(w, op, d, s));
    tick();
    set_in(k, 1'b0, 2'($urandom), $urandom, 5'($urandom));
    n = 0;
    get_out(k, v, r, q);
    while (!v && n < 40) begin
      tick();
      n++;
      get_out(k, v, r, q);
    end
    check({tag, " latency"}, 32'(n), 32'(ncyc));
    e = exp_q.pop_front();
    check({tag, " data"}, q, e);
    if (complete) begin
      tick();
      get_out(k, v, r, q);
      check({tag, " valid drop"}, 32'(v), 32'd0);
      check({tag, " ready back"}, 32'(r), 32'd1);
    end
  endtask

  initial begin
    logic v, r;
    logic [31:0] q, hold;
    reset_n = 1'b0;
    set_in(0, 1'b0, 2'b00, '0, '0);
    set_in(1, 1'b0, 2'b00, '0, '0);
    set_in(2, 1'b0, 2'b00, '0, '0);
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    tick(); tick();
    check("rst out_valid", 32'(ov0), 32'd0);
    check("rst out_data", q0, 32'd0);
    check("rst in_ready low", 32'(ir0), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst release in_ready", 32'(ir0), 32'd1);

    run_op(0, 32, 5, 2'b10, 32'h8000_0000, 16, 1, "sra16");
    check("sra16 exact", q0, 32'hFFFF_8000);
    run_op(0, 32, 5, 2'b01, 32'h8000_0000, 16, 1, "srl16");
    check("srl16 exact", q0, 32'h0000_8000);
    run_op(0, 32, 5, 2'b00, 32'h0000_0001, 31, 1, "sll31");
    check("sll31 exact", q0, 32'h8000_0000);
    run_op(0, 32, 5, 2'b10, 32'h7FFF_FFFF, 31, 1, "sra31");
    check("sra31 exact", q0, 32'h0000_0000);
    run_op(0, 32, 5, 2'b11, 32'h0000_0001, 1, 1, "ror1");
    check("ror1 exact", q0, 32'h8000_0000);
    run_op(0, 32, 5, 2'b11, 32'h1234_5678, 0, 1, "ror0");
    check("ror0 exact", q0, 32'h1234_5678);

    // Back-pressure: result must hold and no new request may slip in.
    or0 = 1'b0;
    run_op(0, 32, 5, 2'b11, 32'hDEAD_BEEF, 8, 0, "bp");
    hold = model(32, 2'b11, 32'hDEAD_BEEF, 8);
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1'(i % 2 == 0), 2'($urandom), $urandom, 5'($urandom));
      tick();
      check("bp valid held", 32'(ov0), 32'd1);
      check("bp data held", q0, hold);
      check("bp in_ready low", 32'(ir0), 32'd0);
    end
    set_in(0, 1'b0, 2'b00, '0, '0);
    or0 = 1'b1;
    tick();
    check("bp transfer valid", 32'(ov0), 32'd0);
    check("bp transfer ready", 32'(ir0), 32'd1);
    check("bp data kept", q0, hold);
    repeat (7) tick();
    check("bp no second op", 32'(ov0), 32'd0);

    // Reset during the 2nd SHIFT cycle discards the operation.
    set_in(0, 1'b1, 2'b00, 32'h0000_00FF, 5'd4);
    tick();
    set_in(0, 1'b0, 2'b00, '0, '0);
    tick();
    reset_n = 1'b0;
    #1;
    check("mid rst in_ready", 32'(ir0), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("mid rst out_valid", 32'(ov0), 32'd0);
    check("mid rst out_data", q0, 32'd0);
    check("mid rst in_ready", 32'(ir0), 32'd1);
    repeat (6) tick();
    check("mid rst discarded", 32'(ov0), 32'd0);
    run_op(0, 32, 5, 2'b00, 32'h0000_0003, 2, 1, "post rst sll");
    check("post rst exact", q0, 32'h0000_000C);

    run_op(1, 32, 3, 2'b10, 32'hF000_0000, 4, 1, "s2 sra4");
    check("s2 sra4 exact", q1, 32'hFF00_0000);
    for (int i = 0; i < 1000; i++)
      run_op(1, 32, 3, 2'($urandom), $urandom, int'($urandom_range(31, 0)), 1, "s2 rand");

    run_op(2, 8, 1, 2'b10, 32'h0000_0090, 3, 1, "w8 sra3");
    check("w8 sra3 exact", {24'd0, q2}, 32'h0000_00F2);
    for (int op = 0; op < 4; op++)
      for (int dv = 0; dv < 256; dv++)
        for (int s = 0; s < 8; s++)
          run_op(2, 8, 1, 2'(op), 32'(dv), s, 1, "w8 sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
